// File: rtl/insn_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: word width,
// default parameter values and the {pc, data} entry held in the fetch FIFO.
package insn_fetch_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESETVECTOR_DEF = 32'h0000_1000;
    localparam int                DEPTH_DEF       = 4;
    localparam int                MAX_OUT_DEF     = 2;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/insn_fetch_if.sv
// Bundles the instruction-memory read port and the decode-side handshake.
// master = fetch stage, slave = the environment (memory + decode).
interface insn_fetch_if;
    import insn_fetch_pkg::*;

    // instruction memory read port
    logic              mem_req;
    logic [WORD_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [WORD_W-1:0] mem_rdata;

    // decode handshake
    logic              insn_valid;
    logic [WORD_W-1:0] insn_data;
    logic [WORD_W-1:0] insn_pc;
    logic              insn_ready;

    modport master (
        output mem_req, mem_addr, insn_valid, insn_data, insn_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, insn_ready
    );

    modport slave (
        input  mem_req, mem_addr, insn_valid, insn_data, insn_pc,
        output mem_gnt, mem_rvalid, mem_rdata, insn_ready
    );

endinterface

// File: rtl/insn_fetch_fifo.sv
// Small synchronous FIFO of {pc, data} entries. The head is read straight
// from the storage array, so a word pushed at one edge is visible after it
// and an empty FIFO never forwards its input. Flush empties it in one cycle.
module insn_fetch_fifo
    import insn_fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           entry_i,
    output logic [$clog2(DEPTH):0] count_o,
    output fetch_entry_t           head_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    fetch_entry_t  mem_q [DEPTH];

    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    // Pointer and occupancy next-state; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
            else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/insn_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads under a
// credit limit, tags in-order responses with their PC, buffers them for
// decode, and on a redirect flushes the buffer and drops every read still
// in flight so no stale word reaches decode.
module insn_fetch
    import insn_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESETVECTOR = RESETVECTOR_DEF,
    parameter int                DEPTH       = DEPTH_DEF,
    parameter int                MAX_OUT     = MAX_OUT_DEF
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              halt,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    insn_fetch_if.master      bus,
    output logic              proto_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    localparam logic [OW-1:0]     MAX_OUT_CNT = OW'(MAX_OUT);
    localparam logic [SW-1:0]     DEPTH_CNT   = SW'(DEPTH);
    localparam logic [OW-1:0]     OUT_ONE     = OW'(1);
    localparam logic [WORD_W-1:0] PC_ONE      = WORD_W'(1);

    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_W-1:0] resp_pc_q,  resp_pc_d;
    logic [OW-1:0]     out_q,      out_d;
    logic [OW-1:0]     drop_q,     drop_d;
    logic              proto_err_q, proto_err_d;

    logic [CW-1:0]     fifo_count;
    fetch_entry_t      fifo_head;
    fetch_entry_t      push_entry;
    logic [SW-1:0]     credit_used;
    logic              mem_req;
    logic              grant;
    logic              rsp_ok;
    logic              rsp_bad;
    logic              push;
    logic              pop;

    // Buffered words plus reads in flight must never exceed the FIFO size,
    // which is what guarantees a response always has a slot to land in.
    assign credit_used = SW'(fifo_count) + SW'(out_q);
    assign mem_req     = _reset && !halt && !redirect &&
                         (out_q < MAX_OUT_CNT) && (credit_used < DEPTH_CNT);
    assign grant       = mem_req && bus.mem_gnt;
    assign rsp_ok      = bus.mem_rvalid && (out_q != '0);
    assign rsp_bad     = bus.mem_rvalid && (out_q == '0);

    assign pop         = (fifo_count != '0) && bus.insn_ready && !redirect;
    assign push_entry  = '{pc: resp_pc_q, data: bus.mem_rdata};

    // Issue, response, drop and redirect bookkeeping; redirect overrides the rest.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        out_d       = out_q;
        drop_d      = drop_q;
        proto_err_d = proto_err_q || rsp_bad;
        push        = 1'b0;

        if (grant && !rsp_ok)      out_d = out_q + OUT_ONE;
        else if (!grant && rsp_ok) out_d = out_q - OUT_ONE;

        if (grant) fetch_pc_d = fetch_pc_q + PC_ONE;

        if (rsp_ok) begin
            if (drop_q != '0) begin
                drop_d = drop_q - OUT_ONE;
            end else begin
                push      = 1'b1;
                resp_pc_d = resp_pc_q + PC_ONE;
            end
        end

        // mem_req is low during a redirect, so out_d already equals the
        // number of reads that will still be in flight: drop all of them.
        if (redirect) begin
            push       = 1'b0;
            drop_d     = out_d;
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
        end
    end

    // Fetch control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            fetch_pc_q  <= RESETVECTOR;
            resp_pc_q   <= RESETVECTOR;
            out_q       <= '0;
            drop_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            proto_err_q <= proto_err_d;
        end
    end

    insn_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n_i (_reset),
        .push_i    (push),
        .pop_i     (pop),
        .flush_i   (redirect),
        .entry_i   (push_entry),
        .count_o   (fifo_count),
        .head_o    (fifo_head)
    );

    assign bus.mem_req    = mem_req;
    assign bus.mem_addr   = fetch_pc_q;
    assign bus.insn_valid = (fifo_count != '0);
    assign bus.insn_data  = fifo_head.data;
    assign bus.insn_pc    = fifo_head.pc;
    assign proto_err      = proto_err_q;

endmodule

// File: doc/insn_fetch.md
Name: insn_fetch

Overview:
- Instruction-fetch stage directly upstream of the core's decode/exec path.
- Owns the fetch PC and issues word-addressed reads to instruction memory. Tolerates variable, in-order read latency.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects (jumps, reset vector) by flushing buffered words and discarding responses already in flight.

Parameters:
- RESETVECTOR, 32'h00001000, first fetch address after reset.
- DEPTH, 4, instruction FIFO entries (power of two, >= 2).
- MAX_OUT, 2, maximum outstanding memory reads (1..DEPTH).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- _reset  input  1  synchronous, active-low reset.
- halt  input  1  when high, no new reads are issued; in-flight reads still complete and are buffered.
- redirect  input  1  one-cycle pulse; the next fetch comes from redirect_pc.
- redirect_pc  input  32  redirect target word address.
- mem_req  output  1  read request valid.
- mem_addr  output  32  read word address.
- mem_gnt  input  1  request accepted this cycle.
- mem_rvalid  input  1  read data valid; responses arrive in request order.
- mem_rdata  input  32  read data.
- insn_valid  output  1  FIFO head valid.
- insn_data  output  32  instruction word at the FIFO head.
- insn_pc  output  32  address of insn_data.
- insn_ready  input  1  decode consumes the head when insn_valid is also high.
- proto_err  output  1  sticky flag: unexpected mem_rvalid.

Behaviour:
- Reset (_reset low at posedge):
  - fetch_pc = resp_pc = RESETVECTOR.
  - FIFO empty; outstanding = 0; drop = 0; proto_err = 0.
  - Outputs: mem_req = 0, insn_valid = 0, mem_addr = RESETVECTOR.
  - A reset during an active read discards that read's response: drop is cleared, and the response is ignored without raising proto_err, for 1 cycle after reset only if the memory is also reset. The memory is reset alongside this block.
- Issue:
  - mem_req = !halt && !redirect && outstanding < MAX_OUT && (count + outstanding) < DEPTH.
  - mem_addr = fetch_pc.
  - Accepted request (mem_req && mem_gnt): fetch_pc += 1 (32-bit wrap, 32'hFFFFFFFF -> 0); outstanding += 1.
  - mem_req stays high until granted; mem_addr is stable while mem_req is high.
  - First mem_req is high in the first cycle after _reset rises.
- Response (mem_rvalid):
  - outstanding -= 1.
  - If drop > 0: drop -= 1 and the word is discarded.
  - Otherwise push {resp_pc, mem_rdata} and resp_pc += 1.
  - If outstanding == 0 and drop == 0: ignore the response and set proto_err.
  - A grant and a response in the same cycle leave outstanding unchanged.
- Overflow: the credit rule guarantees no push when the FIFO is full. A push in that condition is a design error and is asserted in the bench.
- Output:
  - insn_valid = (count != 0).
  - The head is registered, so a word returned at cycle N is visible at N+1.
  - Pop when insn_valid && insn_ready.
  - Push and pop in the same cycle leave count unchanged; a push into an empty FIFO with a simultaneous ready does not bypass.
- Redirect (takes priority over every other event in that cycle):
  - FIFO flushed, so insn_valid = 0 next cycle; any pop in that cycle is void.
  - drop = outstanding + (mem_req && mem_gnt ? 1 : 0) - (mem_rvalid ? 1 : 0) + drop adjustment.
  - In effect, every read in flight after this cycle is dropped.
  - fetch_pc = resp_pc = redirect_pc.
  - mem_req is forced low in the redirect cycle; issue resumes the next cycle.
- halt:
  - Blocks issue only; buffered words still drain to decode.
  - A redirect during halt still flushes and retargets.
  - Deasserting halt resumes at fetch_pc with no skipped or repeated address.
- Counter widths: count is log2(DEPTH)+1 bits; outstanding and drop are log2(MAX_OUT)+1 bits.

Decomposition:
- Shared package (common.vh), with the block's parameters defaulted from it:
  - RESETVECTOR default.
  - Word width 32.
  - Fetch defaults DEPTH and MAX_OUT.
- One sub-module: fetch_fifo.
  - Synchronous FIFO, 64-bit {pc,data} entries, DEPTH deep.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - Synchronous reset shared with the parent.
- insn_fetch keeps the issue, credit, drop and PC logic.

Test Plan:
- Reset then zero-latency memory (gnt=1, rvalid one cycle after each grant), insn_ready=1 -> mem_addr runs 0x1000, 0x1001, ...; insn_pc/insn_data appear in order; first insn_valid 3 cycles after _reset rises.
- insn_ready=0 held with DEPTH=4, MAX_OUT=2 -> exactly 4 words buffered; mem_req low thereafter; no overflow; releasing ready drains 0x1000..0x1003 in order.
- Two reads outstanding (latency 3), redirect to 0x2000 -> both stale responses dropped; next insn_pc = 0x2000; no word from 0x100x emerges after the redirect.
- Redirect in the same cycle as mem_rvalid and as a grant -> drop count correct; first delivered word has insn_pc = redirect_pc.
- halt raised mid-stream with 1 read outstanding -> that word is still delivered; mem_req stays low; dropping halt resumes at the next sequential address.
- mem_rvalid pulsed with nothing outstanding -> proto_err rises and stays high; FIFO unchanged; _reset low clears it.
